sum_block_accum: RTL and testbench
==================================

# sum_block_accum

Downstream consumer of the three-adder datapath. Takes the 8-bit adder sum as a valid/ready stream and accumulates a fixed-length block of samples. Per block it records the total, minimum, maximum and an overflow flag, then presents the result on a held output handshake. It decouples the free-running adder from slower result consumers, with backpressure on the input while a result is pending.

## Interface
- DATA_W, 8, sample width (matches adder output)
- ACC_W, 12, accumulator/total width; must be ≥ DATA_W
- BLK_LEN, 4, samples per block; legal range 1..255
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  DATA_W  adder sum sample
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample; transfer when in_valid && in_ready at clk edge
- out_total  out  ACC_W  block sum
- out_min  out  DATA_W  smallest sample in block
- out_max  out  DATA_W  largest sample in block
- out_ovf  out  1  total exceeded 2^ACC_W-1 during block
- out_valid  out  1  result held and stable
- out_ready  in  1  consumer takes result; transfer when out_valid && out_ready at clk edge
- busy  out  1  partial block in progress or result pending

## Operation
- Two states: ACC and HOLD. Reset enters ACC.
- ACC:
  - in_ready=1.
  - Each accepted sample: total += in_data (zero-extended to ACC_W+1 internally). min/max updated. Sample count increments.
  - The first sample of a block loads min and max directly.
  - ovf is sticky within the block: set when any addition carries out of ACC_W bits.
  - When the accepted sample is number BLK_LEN, load out_total/out_min/out_max/out_ovf from the final values, including that sample. Set out_valid and go to HOLD.
- HOLD:
  - in_ready=0; in_valid ignored.
  - All out_* stay constant.
  - On out_valid && out_ready: clear out_valid, clear count/total/ovf internals, return to ACC.
  - out_total/min/max/ovf keep their last values after the handshake until the next block completes.
- in_ready is a combinational decode of the state only; it never depends on in_valid or out_ready.
- busy = (count != 0) || (state == HOLD).
- BLK_LEN=1: every accepted sample produces a result with min = max = total = sample.
- Reset asserted at any time:
  - Discards the partial block or pending result.
  - State ACC, count 0.
  - All outputs return to reset values.
- Reset values: out_total=0, out_min=0, out_max=0, out_ovf=0, out_valid=0, busy=0, in_ready=1.

## Timing
- Result latency: the last sample is accepted at edge k; out_valid=1 and out_* are valid from edge k (visible in cycle k+1).
- HOLD exits at the consuming edge m; in_ready=1 from edge m. The earliest next sample is accepted at edge m+1. There is one dead cycle per block minimum.
- Gaps (in_valid=0) in ACC do not affect count or totals.
- out_valid never drops without a handshake, except on reset.
- All registered outputs are updated only on clk rising edges or asynchronously on rst falling.

## Configuration
- ACC_SAT_EN defined:
  - On carry out of ACC_W bits, total clamps to 2^ACC_W-1 and stays there for the rest of the block.
  - out_ovf=1.
- ACC_SAT_EN undefined:
  - total wraps modulo 2^ACC_W.
  - out_ovf=1 still reports the wrap.
- min/max/handshake behaviour is identical in both builds.

## Test plan
- Basic block: BLK_LEN=4, samples 2,3,4,5 back-to-back, out_ready=1.
  - Required: out_valid high one edge after the 4th accept.
  - out_total=14, out_min=2, out_max=5, out_ovf=0.
  - in_ready low exactly one cycle.
- Backpressure: same block with out_ready=0 for 5 cycles, then 1.
  - Required: in_ready=0 and out_* stable for all 5 cycles.
  - A sample offered during HOLD is not counted; the next block total excludes it.
- Gappy input: samples 10,_,_,20,_,30,40 (underscore = in_valid 0).
  - Required: total=100, min=10, max=40; result appears one edge after the 40 is accepted.
- Overflow: BLK_LEN=20, ACC_W=12, all samples 255.
  - Without ACC_SAT_EN: out_total=1004, out_ovf=1.
  - With ACC_SAT_EN: out_total=4095, out_ovf=1.
- Reset mid-block: accept 7,8, assert rst, release, then accept 1,1,1,1.
  - Required: during reset all outputs at reset values, busy=0.
  - After reset: result total=4, min=1, max=1.
- BLK_LEN=1, samples 9 then 200 with out_ready=1.
  - Required: two results, total/min/max = 9 then 200; one dead cycle between accepts.

Source files
------------

// File: rtl/sum_block_accum.sv
// Block accumulator for the adder sum stream: per block of BLK_LEN samples it
// reports total/min/max/overflow on a held result handshake. Define ACC_SAT_EN to saturate the total.
module sum_block_accum #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 12,
    parameter int BLK_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              dbg_state
);

    // Handshakes: a beat transfers on a rising edge where valid && ready; a
    // producer holds valid and data until that edge, ready never waits on valid.

    localparam int CNT_W = 8;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_LEN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  acc_total;
    logic              acc_ovf;
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;

    logic              accept;
    logic              last;
    logic              take_result;
    logic              first;
    logic [SUM_W-1:0]  sum_ext;
    logic [ACC_W-1:0]  new_total;
    logic              new_ovf;
    logic [DATA_W-1:0] new_min;
    logic [DATA_W-1:0] new_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        accept      = 1'b0;
        last        = 1'b0;
        take_result = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                accept   = in_valid;
                last     = in_valid && (count == LAST_IDX);
                if (last) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                take_result = out_ready;
                if (out_ready) begin
                    next_state = ACC;
                end
            end
            default: next_state = ACC;
        endcase
    end

    // Carry out of ACC_W bits is the overflow event in both builds.
    always_comb begin
        first   = (count == '0);
        sum_ext = {1'b0, acc_total} + SUM_W'(in_data);
        new_ovf = acc_ovf | sum_ext[ACC_W];
`ifdef ACC_SAT_EN
        new_total = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        new_total = sum_ext[ACC_W-1:0];
`endif
        new_min = (first || (in_data < acc_min)) ? in_data : acc_min;
        new_max = (first || (in_data > acc_max)) ? in_data : acc_max;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            acc_total <= '0;
            acc_ovf   <= 1'b0;
            acc_min   <= '0;
            acc_max   <= '0;
            out_total <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (take_result) begin
            out_valid <= 1'b0;
            count     <= '0;
            acc_total <= '0;
            acc_ovf   <= 1'b0;
        end else if (accept) begin
            count     <= count + CNT_W'(1);
            acc_total <= new_total;
            acc_ovf   <= new_ovf;
            acc_min   <= new_min;
            acc_max   <= new_max;
            if (last) begin
                out_total <= new_total;
                out_min   <= new_min;
                out_max   <= new_max;
                out_ovf   <= new_ovf;
                out_valid <= 1'b1;
            end
        end
    end

    assign busy      = (count != '0) || (state == HOLD);
    assign dbg_state = state;

endmodule

// File: tb/tb_sum_block_accum.sv
// Bench for sum_block_accum: three instances (BLK_LEN 4, 20, 1) checked
// against a block-level arithmetic model of total/min/max/overflow.
module tb_sum_block_accum;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // BLK_LEN = 4 instance
    logic [7:0]  in4_data = '0;
    logic        in4_valid = 1'b0;
    logic        in4_ready;
    logic [11:0] out4_total;
    logic [7:0]  out4_min, out4_max;
    logic        out4_ovf, out4_valid, busy4, dbg4;
    logic        out4_ready = 1'b0;

    // BLK_LEN = 20 instance
    logic [7:0]  in20_data = '0;
    logic        in20_valid = 1'b0;
    logic        in20_ready;
    logic [11:0] out20_total;
    logic [7:0]  out20_min, out20_max;
    logic        out20_ovf, out20_valid, busy20, dbg20;
    logic        out20_ready = 1'b0;

    // BLK_LEN = 1 instance
    logic [7:0]  in1_data = '0;
    logic        in1_valid = 1'b0;
    logic        in1_ready;
    logic [11:0] out1_total;
    logic [7:0]  out1_min, out1_max;
    logic        out1_ovf, out1_valid, busy1, dbg1;
    logic        out1_ready = 1'b0;

    sum_block_accum #(.DATA_W(8), .ACC_W(12), .BLK_LEN(4)) u4 (
        .clk(clk), .rst(rst), .in_data(in4_data), .in_valid(in4_valid), .in_ready(in4_ready),
        .out_total(out4_total), .out_min(out4_min), .out_max(out4_max), .out_ovf(out4_ovf),
        .out_valid(out4_valid), .out_ready(out4_ready), .busy(busy4), .dbg_state(dbg4));

    sum_block_accum #(.DATA_W(8), .ACC_W(12), .BLK_LEN(20)) u20 (
        .clk(clk), .rst(rst), .in_data(in20_data), .in_valid(in20_valid), .in_ready(in20_ready),
        .out_total(out20_total), .out_min(out20_min), .out_max(out20_max), .out_ovf(out20_ovf),
        .out_valid(out20_valid), .out_ready(out20_ready), .busy(busy20), .dbg_state(dbg20));

    sum_block_accum #(.DATA_W(8), .ACC_W(12), .BLK_LEN(1)) u1 (
        .clk(clk), .rst(rst), .in_data(in1_data), .in_valid(in1_valid), .in_ready(in1_ready),
        .out_total(out1_total), .out_min(out1_min), .out_max(out1_max), .out_ovf(out1_ovf),
        .out_valid(out1_valid), .out_ready(out1_ready), .busy(busy1), .dbg_state(dbg1));

    // Reference model: samples of the open block, expected results per block
    int          blk_q[$];
    logic [11:0] exp_total_q[$];
    logic [7:0]  exp_min_q[$];
    logic [7:0]  exp_max_q[$];
    logic [0:0]  exp_ovf_q[$];
    logic [11:0] hold_total;
    logic [7:0]  hold_min, hold_max;
    logic        hold_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_block();
        int sum = 0;
        int mn  = blk_q[0];
        int mx  = blk_q[0];
        foreach (blk_q[i]) begin
            sum += blk_q[i];
            if (blk_q[i] < mn) mn = blk_q[i];
            if (blk_q[i] > mx) mx = blk_q[i];
        end
`ifdef ACC_SAT_EN
        exp_total_q.push_back((sum > 4095) ? 12'd4095 : 12'(sum));
`else
        exp_total_q.push_back(12'(sum % 4096));
`endif
        exp_min_q.push_back(8'(mn));
        exp_max_q.push_back(8'(mx));
        exp_ovf_q.push_back(sum > 4095);
        blk_q.delete();
    endtask

    task automatic check_result(input string tag, input logic valid, input logic [11:0] total,
                                input logic [7:0] mn, input logic [7:0] mx, input logic ovf);
        hold_total = exp_total_q.pop_front();
        hold_min   = exp_min_q.pop_front();
        hold_max   = exp_max_q.pop_front();
        hold_ovf   = exp_ovf_q.pop_front();
        check({tag, ".valid"}, valid, 1);
        check({tag, ".total"}, total, hold_total);
        check({tag, ".min"}, mn, hold_min);
        check({tag, ".max"}, mx, hold_max);
        check({tag, ".ovf"}, ovf, hold_ovf);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one sample to u4 and returns once it has been accepted.
    task automatic push4(input logic [7:0] d);
        int waited = 0;
        in4_data  = d;
        in4_valid = 1'b1;
        while (!in4_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in4_ready) begin
            check("push4_timeout.in_ready", in4_ready, 1);
            in4_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in4_valid = 1'b0;
        blk_q.push_back(int'(d));
        if (blk_q.size() == 4) begin
            model_block();
            check_result("blk4", out4_valid, out4_total, out4_min, out4_max, out4_ovf);
        end
    endtask

    task automatic hold_check4(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("hold.in_ready", in4_ready, 0);
            check("hold.valid", out4_valid, 1);
            check("hold.total", out4_total, hold_total);
            check("hold.min", out4_min, hold_min);
            check("hold.max", out4_max, hold_max);
            check("hold.ovf", out4_ovf, hold_ovf);
        end
    endtask

    task automatic consume4();
        out4_ready = 1'b1;
        @(posedge clk);
        #1;
        out4_ready = 1'b0;
        check("consume.valid", out4_valid, 0);
        check("consume.in_ready", in4_ready, 1);
        check("consume.busy", busy4, 0);
        check("consume.total_kept", out4_total, hold_total);
    endtask

    task automatic reset_vals4(input string tag);
        check({tag, ".total"}, out4_total, 0);
        check({tag, ".min"}, out4_min, 0);
        check({tag, ".max"}, out4_max, 0);
        check({tag, ".ovf"}, out4_ovf, 0);
        check({tag, ".valid"}, out4_valid, 0);
        check({tag, ".busy"}, busy4, 0);
        check({tag, ".in_ready"}, in4_ready, 1);
    endtask

    initial begin
        // Power-on reset
        rst = 1'b0;
        idle(2);
        reset_vals4("por");
        check("por.u20_valid", out20_valid, 0);
        check("por.u1_busy", busy1, 0);
        rst = 1'b1;
        idle(1);

        // Basic block with the consumer always ready
        out4_ready = 1'b1;
        push4(8'd2);
        push4(8'd3);
        push4(8'd4);
        check("basic.busy_mid", busy4, 1);
        push4(8'd5);
        check("basic.hold_in_ready", in4_ready, 0);
        idle(1);
        check("basic.in_ready_back", in4_ready, 1);
        check("basic.valid_cleared", out4_valid, 0);
        check("basic.total_kept", out4_total, 14);
        out4_ready = 1'b0;

        // Backpressure, with a sample offered during HOLD that must be ignored
        push4(8'd2);
        push4(8'd3);
        push4(8'd4);
        push4(8'd5);
        in4_data  = 8'd99;
        in4_valid = 1'b1;
        hold_check4(5);
        in4_valid = 1'b0;
        consume4();
        push4(8'd1);
        push4(8'd1);
        push4(8'd1);
        push4(8'd1);
        check("bp.next_total", out4_total, 4);
        consume4();

        // Gappy input
        push4(8'd10);
        idle(2);
        push4(8'd20);
        idle(1);
        push4(8'd30);
        check("gappy.not_yet_valid", out4_valid, 0);
        push4(8'd40);
        hold_check4(1);
        consume4();

        // Reset in the middle of a block
        push4(8'd7);
        push4(8'd8);
        check("rstmid.busy", busy4, 1);
        rst = 1'b0;
        #1;
        reset_vals4("rstmid.async");
        idle(2);
        reset_vals4("rstmid.held");
        rst = 1'b1;
        blk_q.delete();
        idle(1);
        push4(8'd1);
        push4(8'd1);
        push4(8'd1);
        push4(8'd1);
        check("rstmid.total", out4_total, 4);
        consume4();

        // Overflow on the BLK_LEN=20 instance
        in20_data  = 8'd255;
        in20_valid = 1'b1;
        idle(19);
        check("ovf20.valid_early", out20_valid, 0);
        check("ovf20.busy", busy20, 1);
        idle(1);
        in20_valid = 1'b0;
        repeat (20) blk_q.push_back(255);
        model_block();
        check_result("ovf20", out20_valid, out20_total, out20_min, out20_max, out20_ovf);
        idle(2);
        check("ovf20.held", out20_valid, 1);
        check("ovf20.in_ready", in20_ready, 0);

        // BLK_LEN=1: every sample is a block, one dead cycle between accepts
        out1_ready = 1'b1;
        in1_data   = 8'd9;
        in1_valid  = 1'b1;
        idle(1);
        blk_q.push_back(9);
        model_block();
        check_result("len1.a", out1_valid, out1_total, out1_min, out1_max, out1_ovf);
        check("len1.a_in_ready", in1_ready, 0);
        in1_data = 8'd200;
        idle(1);
        check("len1.dead_valid", out1_valid, 0);
        check("len1.dead_in_ready", in1_ready, 1);
        idle(1);
        in1_valid = 1'b0;
        blk_q.push_back(200);
        model_block();
        check_result("len1.b", out1_valid, out1_total, out1_min, out1_max, out1_ovf);

        // Randomized blocks with random gaps and consumer delays
        for (int b = 0; b < 8; b++) begin
            for (int s = 0; s < 4; s++) begin
                idle($urandom_range(0, 2));
                push4(8'($urandom_range(0, 255)));
            end
            hold_check4($urandom_range(0, 3));
            consume4();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
